fetch: RTL and testbench

Instruction-fetch stage: owns the PC, issues word requests to instruction memory over a req/ack handshake, and registers the fetched instruction and its PC into if_de_cword for decode.
- Absorbs downstream stalls with a one-entry skid buffer.
- Handles branch/jump redirects from execute, including discarding a response that is still in flight.
- Inserts NOP bubbles whenever no valid instruction is available.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/fetch.sv | 108 ++++++++++
 tb/tb_fetch.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The decode control word is defined here so fetch can build bubbles and real entries.
package fetch_pkg;

  localparam int          RVGA_XLEN     = 32;
  localparam logic [31:0] RVGA_NOP      = 32'h0000_0013;
  localparam int          rvga_wordsize = 4;

  // Decode control word; fetch only fills .pc and .inst.
  typedef struct packed {
    logic [RVGA_XLEN-1:0] pc;
    logic [RVGA_XLEN-1:0] inst;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [6:0]           opcode;
    logic                 valid;
  } rvga_cword;

  typedef enum logic [1:0] {
    FS_REQ     = 2'd0,
    FS_HOLD    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state;

  function automatic rvga_cword make_cword(input logic [RVGA_XLEN-1:0] pc,
                                           input logic [RVGA_XLEN-1:0] inst);
    rvga_cword c;
    c      = '0;
    c.pc   = pc;
    c.inst = inst;
    return c;
  endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch: owns the PC, issues req/ack word fetches, and registers
// {inst, pc} for decode with a one-entry skid buffer and redirect handling.
module fetch
  import fetch_pkg::*;
#(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output rvga_cword       if_de_cword
);

  localparam logic [XLEN-1:0] WORD_INC = XLEN'(rvga_wordsize);

  fetch_state      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] disc_addr_q, disc_addr_d;
  rvga_cword       buf_q, buf_d;
  rvga_cword       cword_q, cword_d;

  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_inc;

  assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc   = pc_q + WORD_INC;

  // In DISCARD the old request must stay on the bus until its ack drains it.
  assign imem_req    = !rst && (state_q != FS_HOLD);
  assign imem_addr   = (state_q == FS_DISCARD) ? disc_addr_q : pc_q;
  assign if_de_cword = cword_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    buf_d       = buf_q;
    cword_d     = cword_q;
    unique case (state_q)
      FS_REQ: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          cword_d = make_cword(redir_pc, NOP_INST);
          if (!imem_ack) begin
            disc_addr_d = pc_q;
            state_d     = FS_DISCARD;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (stall) begin
            buf_d   = make_cword(pc_q, imem_rdata);
            state_d = FS_HOLD;
          end else begin
            cword_d = make_cword(pc_q, imem_rdata);
          end
        end else if (!stall) begin
          cword_d = make_cword(pc_q, NOP_INST);
        end
      end
      FS_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          cword_d = make_cword(redir_pc, NOP_INST);
          state_d = FS_REQ;
        end else if (!stall) begin
          cword_d = buf_q;
          state_d = FS_REQ;
        end
      end
      FS_DISCARD: begin
        // Latest redirect wins; the in-flight response is dropped on ack.
        if (redirect_valid) begin
          pc_d    = redir_pc;
          cword_d = make_cword(redir_pc, NOP_INST);
        end else if (!stall) begin
          cword_d = make_cword(pc_q, NOP_INST);
        end
        if (imem_ack) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FS_REQ;
      pc_q        <= RESET_PC;
      disc_addr_q <= '0;
      buf_q       <= '0;
      cword_q     <= make_cword(RESET_PC, NOP_INST);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      buf_q       <= buf_d;
      cword_q     <= cword_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: latency-programmable memory model, stalls,
// redirects (in flight and in HOLD), PC wrap and reset mid-request.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0080;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  rvga_cword   if_de_cword;

  int          lat;
  int          cnt;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fetch #(.XLEN(32), .RESET_PC(RST_PC), .NOP_INST(NOP)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_de_cword    (if_de_cword)
  );

  // Memory: acks after `lat` extra cycles of continuous request.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) cnt <= 0;
    else                              cnt <= cnt + 1;
  end
  assign imem_ack   = imem_req && (cnt == lat);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic rvga_cword cw(input logic [31:0] pc, input logic [31:0] inst);
    rvga_cword c;
    c      = '0;
    c.pc   = pc;
    c.inst = inst;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cw(input string tag, input rvga_cword exp);
    n_vec++;
    assert (if_de_cword === exp) else begin
      n_err++;
      $error("FAIL %s: got pc=%h inst=%h (raw %h) expected pc=%h inst=%h", tag,
             if_de_cword.pc, if_de_cword.inst, if_de_cword, exp.pc, exp.inst);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat = 0;
    step();
    chk_cw("reset_cword", cw(RST_PC, NOP));
    chk("reset_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_addr", imem_addr, RST_PC);
    chk("first_req", 32'(imem_req), 32'd1);

    // Combinational memory: one instruction per cycle.
    step(); chk_cw("comb0", cw(32'h80, dat(32'h80)));
    step(); chk_cw("comb1", cw(32'h84, dat(32'h84)));
    step(); chk_cw("comb2", cw(32'h88, dat(32'h88)));
    step(); chk_cw("comb3", cw(32'h8C, dat(32'h8C)));

    // Three-cycle latency: two bubbles per instruction, address stable.
    lat = 2;
    step(); chk_cw("lat_bub0", cw(32'h90, NOP)); chk("lat_addr0", imem_addr, 32'h90);
    step(); chk_cw("lat_bub1", cw(32'h90, NOP)); chk("lat_addr1", imem_addr, 32'h90);
    step(); chk_cw("lat_inst", cw(32'h90, dat(32'h90)));

    // Stall arrives with the ack for 0x98; skid buffer holds it.
    lat = 0;
    step(); chk_cw("pre_stall", cw(32'h94, dat(32'h94)));
    stall = 1'b1;
    step(); chk_cw("hold0", cw(32'h94, dat(32'h94))); chk("hold0_req", 32'(imem_req), 32'd0);
    step(); chk_cw("hold1", cw(32'h94, dat(32'h94))); chk("hold1_req", 32'(imem_req), 32'd0);
    step(); chk_cw("hold2", cw(32'h94, dat(32'h94)));
    stall = 1'b0;
    step(); chk_cw("unbuf", cw(32'h98, dat(32'h98)));
    step(); chk_cw("after_unbuf", cw(32'h9C, dat(32'h9C)));

    // Redirect while a slow request is in flight.
    lat = 2;
    step(); chk_cw("rd_bub", cw(32'hA0, NOP));
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step(); chk_cw("rd_bubble", cw(32'h100, NOP));
    chk("rd_old_addr", imem_addr, 32'hA0);
    chk("rd_old_req", 32'(imem_req), 32'd1);
    redirect_valid = 1'b0;
    step(); chk_cw("rd_drop", cw(32'h100, NOP));
    chk("rd_new_addr", imem_addr, 32'h100);
    step(); chk_cw("rd_wait0", cw(32'h100, NOP));
    step(); chk_cw("rd_wait1", cw(32'h100, NOP));
    step(); chk_cw("rd_first", cw(32'h100, dat(32'h100)));

    // Redirect in HOLD under stall: misaligned target, buffer discarded.
    lat = 0;
    stall = 1'b1;
    step(); chk_cw("h_hold", cw(32'h100, dat(32'h100))); chk("h_req", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step(); chk_cw("h_redir", cw(32'h200, NOP));
    redirect_valid = 1'b0; stall = 1'b0;
    #1;
    chk("h_addr", imem_addr, 32'h200);
    step(); chk_cw("h_first", cw(32'h200, dat(32'h200)));

    // Redirect coinciding with ack, then PC wrap at the top of memory.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    step(); chk_cw("w_redir", cw(32'hFFFF_FFFC, NOP));
    redirect_valid = 1'b0;
    step(); chk_cw("w_top", cw(32'hFFFF_FFFC, dat(32'hFFFF_FFFC)));
    chk("w_wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of a pending request.
    lat = 2;
    step(); chk_cw("r_bub", cw(32'h0, NOP));
    rst = 1'b1;
    #1;
    chk("r_req_low", 32'(imem_req), 32'd0);
    step(); chk_cw("r_cword", cw(RST_PC, NOP));
    rst = 1'b0;
    #1;
    chk("r_reissue_req", 32'(imem_req), 32'd1);
    chk("r_reissue_addr", imem_addr, RST_PC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
